mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
Modular exponentiation controller computing result = x^e mod M by left-to-right binary square-and-multiply in the Montgomery domain. It is the initiator side of the montgomery start/done protocol: it drives operands and a start pulse into one montgomery multiplier instance and consumes its result/done. It sits between the top-level RSA datapath/register interface and the montgomery core, which shares the same clock and reset.

Parameters:
WIDTH, 1024, operand/modulus width in bits; Montgomery radix R = 2^WIDTH
E_WIDTH, 1024, exponent width in bits; all E_WIDTH bits are scanned, MSB first

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
start  input  1  one-cycle request; operands sampled in that cycle
in_x  input  WIDTH  base, x < M
in_e  input  E_WIDTH  exponent
in_m  input  WIDTH  odd modulus
in_rmodm  input  WIDTH  R mod M
in_r2modm  input  WIDTH  R^2 mod M
result  output  WIDTH  x^e mod M, valid from done pulse until next accepted start
done  output  1  one-cycle pulse when result is valid
busy  output  1  high from accepted start until done pulse (inclusive)
mont_start  output  1  one-cycle pulse to multiplier
mont_a  output  WIDTH  multiplier operand A
mont_b  output  WIDTH  multiplier operand B
mont_m  output  WIDTH  multiplier modulus, equals registered M
mont_result  input  WIDTH  multiplier result = A*B*R^-1 mod M
mont_done  input  1  multiplier completion pulse; mont_result valid that cycle

Behaviour:
- Clock clk, reset resetn: synchronous, active-low. Reset: state IDLE, done=0, busy=0, mont_start=0, result=0, mont_a=mont_b=mont_m=0, internal regs (xt, acc, e shift, bit counter) = 0.
- Accepted start: start=1 in IDLE registers x, e, M, R mod M, R^2 mod M; next cycle busy=1. start while busy is ignored (no effect on registers).
- States: IDLE -> TO_MONT -> SQR -> [MUL] -> ... -> FROM_MONT -> DONE -> IDLE.
- Each op state has two phases: ISSUE (drive mont_a/mont_b, mont_start=1 for exactly one cycle) then WAIT (mont_start=0, operands held stable until mont_done). mont_result captured in the mont_done cycle; next state entered the cycle after.
- TO_MONT: A=x, B=R^2 mod M -> xt; acc initialised to R mod M.
- SQR: A=B=acc -> acc. Then if current exponent MSB =1 go MUL, else advance bit.
- MUL: A=acc, B=xt -> acc; then advance bit.
- Advance bit: shift e left 1, counter+1; after E_WIDTH bits processed go FROM_MONT, else SQR.
- FROM_MONT: A=acc, B=1 -> result register.
- DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE with busy=0.
- Op count per run = 2 + E_WIDTH + popcount(e); no leading-zero skipping.
- mont_m = registered M for the whole run.
- mont_done outside a WAIT phase is ignored.
- e=0: no MUL ops; result = 1 (for M>1).
- Reset asserted mid-run: next edge returns to IDLE with all reset values; no done pulse; partial result discarded.
- start coincident with the done cycle is ignored (controller not in IDLE).

Test Plan:
- WIDTH=8, E_WIDTH=8, behavioural montgomery model: x=0x03, e=0x05, M=0xC5, rmodm=0x3B, r2modm=0x84 -> result=0x2E, exactly 12 mont_start pulses, one done pulse.
- Same M: x=0x03, e=0xC4 (Fermat, e=M-1) -> result=0x01, 13 mont ops.
- e=0x00, x=0x03 -> result=0x01, 10 mont ops, no MUL; x=0x00, e=0x05 -> result=0x00.
- Pulse start again at 3rd mont_start of a run with different x -> ignored; result still 0x2E for first run.
- Assert resetn=0 for one cycle during the 5th WAIT -> busy=0, done never pulses, mont_start=0; new start afterwards yields correct 0x2E.
- WIDTH=E_WIDTH=1024 with real montgomery core and the team's 1024-bit vector generator -> result matches generated x^e mod M; mont_a/mont_b stable during every WAIT (assertion).

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// x^e mod M by MSB-first square-and-multiply over one Montgomery multiplier; (2 + E_WIDTH + popcount(e)) ops plus issue/done cycles.
// start is ignored while busy; each op issues once and holds its operands until mont_done.
module mont_exp_ctrl #(
  parameter int WIDTH   = 1024,
  parameter int E_WIDTH = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_rmodm,
  input  logic [WIDTH-1:0]   in_r2modm,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               busy,
  output logic               mont_start,
  output logic [WIDTH-1:0]   mont_a,
  output logic [WIDTH-1:0]   mont_b,
  output logic [WIDTH-1:0]   mont_m,
  input  logic [WIDTH-1:0]   mont_result,
  input  logic               mont_done
);

  localparam int CW = $clog2(E_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TO_MONT, S_SQR, S_MUL, S_FROM_MONT, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic               wait_ph, wait_ph_nxt;
  logic [WIDTH-1:0]   x_r, m_r, rmodm_r, r2_r, xt, acc, result_r;
  logic [E_WIDTH-1:0] e_sh;
  logic [CW-1:0]      bit_cnt;
  logic               op_state, op_done, last_bit, e_msb;

  assign op_state = (state == S_TO_MONT) || (state == S_SQR) ||
                    (state == S_MUL) || (state == S_FROM_MONT);
  // mont_done only counts while an op is outstanding.
  assign op_done  = op_state && wait_ph && mont_done;
  assign last_bit = (bit_cnt == CW'(E_WIDTH - 1));
  assign e_msb    = e_sh[E_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      wait_ph <= 1'b0;
    end else begin
      state   <= state_nxt;
      wait_ph <= wait_ph_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_ph_nxt = wait_ph;
    mont_start  = 1'b0;
    mont_a      = '0;
    mont_b      = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_TO_MONT;
          wait_ph_nxt = 1'b0;
        end
      end
      S_TO_MONT, S_SQR, S_MUL, S_FROM_MONT: begin
        mont_start = !wait_ph;
        if (!wait_ph) begin
          wait_ph_nxt = 1'b1;
        end else if (mont_done) begin
          wait_ph_nxt = 1'b0;
          case (state)
            S_TO_MONT: state_nxt = S_SQR;
            S_SQR:     state_nxt = e_msb ? S_MUL : (last_bit ? S_FROM_MONT : S_SQR);
            S_MUL:     state_nxt = last_bit ? S_FROM_MONT : S_SQR;
            default:   state_nxt = S_DONE;
          endcase
        end
        case (state)
          S_TO_MONT: begin mont_a = x_r; mont_b = r2_r; end
          S_SQR:     begin mont_a = acc; mont_b = acc;  end
          S_MUL:     begin mont_a = acc; mont_b = xt;   end
          default:   begin mont_a = acc; mont_b = WIDTH'(1); end
        endcase
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_r      <= '0;
      m_r      <= '0;
      rmodm_r  <= '0;
      r2_r     <= '0;
      xt       <= '0;
      acc      <= '0;
      e_sh     <= '0;
      bit_cnt  <= '0;
      result_r <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        x_r     <= in_x;
        m_r     <= in_m;
        rmodm_r <= in_rmodm;
        r2_r    <= in_r2modm;
        e_sh    <= in_e;
        bit_cnt <= '0;
      end
      if (op_done) begin
        case (state)
          S_TO_MONT: begin
            xt  <= mont_result;
            acc <= rmodm_r;
          end
          S_SQR: begin
            acc <= mont_result;
            // A set bit defers the shift until its multiply completes.
            if (!e_msb) begin
              e_sh    <= e_sh << 1;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          S_MUL: begin
            acc     <= mont_result;
            e_sh    <= e_sh << 1;
            bit_cnt <= bit_cnt + CW'(1);
          end
          default: result_r <= mont_result;
        endcase
      end
    end
  end

  assign result = result_r;
  assign mont_m = m_r;
  assign done   = (state == S_DONE);
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl at 8-bit width against a behavioural multiplier and plain-arithmetic x^e mod M.
module tb_mont_exp_ctrl;
  localparam int W  = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_m = '0, in_rmodm = '0, in_r2modm = '0;
  logic [EW-1:0] in_e = '0;
  logic [W-1:0]  result, mont_a, mont_b, mont_m, mont_result;
  logic          done, busy, mont_start, mont_done;

  logic          mdl_done = 1'b0, spur_done = 1'b0;
  logic [W-1:0]  mdl_res = '0, spur_res = '0;
  logic [W-1:0]  la = '0, lb = '0, lm = '0;
  logic          pend = 1'b0;
  int            cnt = 0;
  int            stab_err = 0;
  int            checks = 0, failures = 0;
  logic          rst_busy, rst_ms, rst_done;
  logic [W-1:0]  rst_result, rst_mm;

  assign mont_done   = mdl_done | spur_done;
  assign mont_result = spur_done ? spur_res : mdl_res;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.WIDTH(W), .E_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_rmodm(in_rmodm), .in_r2modm(in_r2modm),
    .result(result), .done(done), .busy(busy),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done)
  );

  // a*b*R^-1 mod m, found as the r with r*R == a*b (mod m)
  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
    int ab;
    if (m == 0) return '0;
    ab = (int'(a) * int'(b)) % int'(m);
    for (int r = 0; r < int'(m); r++)
      if (((r * 256) % int'(m)) == ab) return W'(r);
    return '0;
  endfunction

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input logic [EW-1:0] e,
                                           input logic [W-1:0] m);
    int r;
    r = 1 % int'(m);
    for (int i = 0; i < int'(e); i++) r = (r * int'(x)) % int'(m);
    return W'(r);
  endfunction

  // Multiplier model with random latency; also watches operand stability.
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (!resetn) begin
      pend <= 1'b0;
    end else if (mont_start) begin
      la   <= mont_a;
      lb   <= mont_b;
      lm   <= mont_m;
      pend <= 1'b1;
      cnt  <= int'($urandom_range(1, 4));
    end else if (pend) begin
      if (mont_a !== la || mont_b !== lb || mont_m !== lm) stab_err <= stab_err + 1;
      if (cnt == 1) begin
        mdl_done <= 1'b1;
        mdl_res  <= mont_ref(la, lb, lm);
        pend     <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // inj_start: N = pulse start at Nth mont_start, 99 = pulse start in the done cycle
  task automatic run(input logic [W-1:0] x, input logic [EW-1:0] e, input logic [W-1:0] m,
                     input int inj_start, input int inj_reset, input int tail_len,
                     output logic [W-1:0] res, output int ops, output int dn, output bit tmo);
    bit s_inj, r_inj, ending;
    int tail;
    s_inj = 0; r_inj = 0; ending = 0; tail = 0;
    ops = 0; dn = 0; tmo = 1; res = '0;
    @(negedge clk);
    in_x = x; in_e = e; in_m = m;
    in_rmodm = W'(256 % int'(m));
    in_r2modm = W'(65536 % int'(m));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_x = W'($urandom); in_e = EW'($urandom); in_m = W'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if (start) start = 1'b0;
      if (!resetn) begin
        resetn = 1'b1;
        rst_busy = busy; rst_ms = mont_start; rst_done = done;
        rst_result = result; rst_mm = mont_m;
        ending = 1;
      end
      if (mont_start) ops++;
      if (done) begin
        dn++;
        res = result;
        ending = 1;
        if (inj_start == 99) begin start = 1'b1; in_x = 8'h07; end
      end
      if (!s_inj && inj_start > 0 && inj_start != 99 && ops == inj_start && mont_start) begin
        s_inj = 1; start = 1'b1; in_x = 8'h07;
      end
      if (!r_inj && inj_reset > 0 && ops == inj_reset && busy && !mont_start) begin
        r_inj = 1; resetn = 1'b0;
      end
      if (ending) begin
        if (tail >= tail_len) begin tmo = 0; break; end
        tail++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({done, busy, mont_start} !== 3'b000 || result !== '0 || mont_a !== '0 ||
        mont_b !== '0 || mont_m !== '0) begin
      failures++;
      $display("FAIL reset: done=%b busy=%b ms=%b result=%h a=%h b=%h m=%h, want all zero",
               done, busy, mont_start, result, mont_a, mont_b, mont_m);
    end
  endtask

  task automatic check_run(input string name, input logic [W-1:0] x, input logic [EW-1:0] e,
                           input logic [W-1:0] m, input int inj, input int tail);
    logic [W-1:0] res, exp_res;
    int ops, dn, exp_ops;
    bit tmo;
    exp_res = ref_pow(x, e, m);
    exp_ops = 2 + EW + $countones(e);
    run(x, e, m, inj, 0, tail, res, ops, dn, tmo);
    checks++;
    if (tmo || res !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %h tmo=%0b, want %h (x=%h e=%h m=%h)", name, res, tmo,
               exp_res, x, e, m);
    end
    checks++;
    if (ops != exp_ops || (tail > 0 && dn != 1)) begin
      failures++;
      $display("FAIL %s ops/done: got ops=%0d done=%0d, want ops=%0d done=1", name, ops, dn,
               exp_ops);
    end
  endtask

  task automatic test_directed;
    check_run("basic_2e", 8'h03, 8'h05, 8'hC5, 0, 4);
    check_run("fermat", 8'h03, 8'hC4, 8'hC5, 0, 4);
    check_run("zero_exp", 8'h03, 8'h00, 8'hC5, 0, 4);
    check_run("zero_base", 8'h00, 8'h05, 8'hC5, 0, 4);
  endtask

  task automatic test_start_while_busy;
    check_run("start_busy", 8'h03, 8'h05, 8'hC5, 3, 6);
    check_run("start_at_done", 8'h03, 8'h05, 8'hC5, 99, 6);
  endtask

  task automatic test_mid_reset;
    logic [W-1:0] res;
    int ops, dn;
    bit tmo;
    run(8'h03, 8'h05, 8'hC5, 0, 5, 10, res, ops, dn, tmo);
    checks++;
    if (tmo || dn != 0 || rst_busy !== 1'b0 || rst_ms !== 1'b0 || rst_done !== 1'b0 ||
        rst_result !== '0 || rst_mm !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: tmo=%0b dn=%0d busy=%b ms=%b done=%b result=%h m=%h, want idle zeros",
               tmo, dn, rst_busy, rst_ms, rst_done, rst_result, rst_mm);
    end
    check_run("after_reset", 8'h03, 8'h05, 8'hC5, 0, 4);
  endtask

  task automatic test_spurious_done;
    logic [W-1:0] prev;
    prev = result;
    @(negedge clk);
    spur_res = 8'hAA; spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mont_start !== 1'b0 || result !== prev) begin
      failures++;
      $display("FAIL spurious_done: busy=%b done=%b ms=%b result=%h, want 0 0 0 %h",
               busy, done, mont_start, result, prev);
    end
  endtask

  task automatic test_back_to_back;
    check_run("b2b_a", 8'h03, 8'h05, 8'hC5, 0, 0);
    check_run("b2b_b", 8'h05, 8'h11, 8'hC5, 0, 0);
    check_run("b2b_c", 8'h02, 8'hFF, 8'h0B, 0, 4);
  endtask

  task automatic test_random;
    logic [W-1:0] m, x;
    logic [EW-1:0] e;
    for (int i = 0; i < 20; i++) begin
      m = W'($urandom_range(1, 127) * 2 + 1);
      x = W'($urandom_range(0, int'(m) - 1));
      e = EW'($urandom);
      check_run("random", x, e, m, 0, 2);
    end
  endtask

  task automatic test_stability;
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL operand_stability: %0d changes during WAIT, want 0", stab_err);
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_mid_reset();
    test_spurious_done();
    test_back_to_back();
    test_random();
    test_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
